library_fetch: RTL and testbench

- Read-back stage downstream of the library store path.
- Given a library slot and a point count, it issues sequential SRAM reads at {4'b0, slot[4:0], idx[10:0]}.
- It absorbs the fixed SRAM read latency and streams the stored (x,y) points out over a valid/ready handshake.
- A small internal FIFO with credit-based read issue ensures no returned word is ever dropped under backpressure.

---
 rtl/library_pkg.sv | 27 ++
 rtl/library_fetch_fifo.sv | 61 ++++++
 rtl/library_fetch.sv | 184 ++++++++++++++++++
 tb/tb_library_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/library_pkg.sv
// Shared types and constants for the library read-back path.
package library_pkg;

    localparam int unsigned LIB_SLOTS     = 26;
    localparam int unsigned LIB_MAX_CNT   = 1024;
    localparam logic [19:0] LIB_PARK_ADDR = 20'h06C00;

    // One stored point as laid out in SRAM: {x[4:0], y[4:0]}.
    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } lib_point_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } fetch_state_t;

    // Saturate a requested point count to the per-slot maximum.
    function automatic logic [10:0] lib_clamp_cnt(input logic [10:0] cnt,
                                                  input logic [10:0] max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/library_fetch_fifo.sv
// Small synchronous FIFO holding returned SRAM points until accepted downstream.
// Storage is cleared on reset so the head reads as zero while empty after reset.
module lib_fetch_fifo
    import library_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  lib_point_t               i_data,
    input  logic                     i_pop,
    output lib_point_t               o_data,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    lib_point_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_cnt;
    logic              w_pop;

    // Pops on an empty FIFO are dropped; pushes rely on upstream credit.
    always_comb begin
        w_pop = i_pop && (r_cnt != '0);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Head of queue and occupancy are presented directly.
    always_comb begin
        o_data = r_mem[r_rptr];
        o_cnt  = r_cnt;
    end

endmodule

// File: rtl/library_fetch.sv
// Library read-back: issues sequential SRAM reads for one slot, absorbs the
// fixed read latency and streams the points out over valid/ready. Reads are
// only issued when FIFO occupancy plus in-flight reads leaves room, so every
// returned word has a guaranteed FIFO entry. FIFO_DEPTH must be >= RD_LAT + 1.
module library_fetch
    import library_pkg::*;
#(
    parameter int unsigned SLOTS      = LIB_SLOTS,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_CNT    = LIB_MAX_CNT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [4:0]  i_slot,
    input  logic [10:0] i_count,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_rd_en,
    output logic [19:0] o_addr,
    input  logic [9:0]  i_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [4:0]  o_x,
    output logic [4:0]  o_y
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;

    logic [4:0]        r_slot;
    logic [10:0]       r_cnt;
    logic [10:0]       r_idx;
    logic [10:0]       r_popped;
    logic [RD_LAT-1:0] r_vld_sr;
    logic              r_done;
    logic              r_err;

    logic              w_slot_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic [10:0]       w_cnt_clamped;
    logic [7:0]        w_inflight;
    logic [7:0]        w_credit_used;
    logic              w_issue;
    logic              w_pop;
    logic              w_push;
    logic [CW-1:0]     w_fifo_cnt;
    lib_point_t        w_head;

    // Start qualification and count clamping.
    always_comb begin
        w_slot_ok     = ({1'b0, i_slot} < 6'(SLOTS));
        w_start_ok    = (r_state == StIdle) && i_start && w_slot_ok;
        w_start_bad   = (r_state == StIdle) && i_start && !w_slot_ok;
        w_cnt_clamped = lib_clamp_cnt(i_count, 11'(MAX_CNT));
    end

    // Reads in flight and the credit they consume together with FIFO occupancy.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_inflight = w_inflight + 8'(r_vld_sr[i]);
        end
        w_credit_used = 8'(w_fifo_cnt) + w_inflight;
        w_push        = r_vld_sr[RD_LAT-1];
        w_pop         = o_valid && i_ready;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    w_state_nxt = (w_cnt_clamped == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (w_issue && ((r_idx + 11'd1) == r_cnt)) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (r_popped == r_cnt) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM outputs: busy, read strobe and address (parked when not reading).
    always_comb begin
        o_busy  = (r_state != StIdle);
        w_issue = (r_state == StFetch) && (r_idx < r_cnt) &&
                  (w_credit_used < 8'(FIFO_DEPTH));
        o_rd_en = w_issue;
        o_addr  = w_issue ? {4'b0, r_slot, r_idx} : LIB_PARK_ADDR;
    end

    // Fetch bookkeeping: latched request, issue index and accepted-point count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot   <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_popped <= '0;
        end else if (w_start_ok) begin
            r_slot   <= i_slot;
            r_cnt    <= w_cnt_clamped;
            r_idx    <= '0;
            r_popped <= '0;
        end else begin
            if (w_issue) begin
                r_idx <= r_idx + 11'd1;
            end
            if (w_pop) begin
                r_popped <= r_popped + 11'd1;
            end
        end
    end

    // Valid shift register tracking reads until their data returns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr[0] <= w_issue;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
        end
    end

    // Registered one-cycle done and error pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == StDone);
            r_err  <= w_start_bad;
        end
    end

    lib_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (lib_point_t'(i_rdata)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_cnt   (w_fifo_cnt)
    );

    // Output stream presents the FIFO head.
    always_comb begin
        o_valid = (w_fifo_cnt != '0);
        o_x     = w_head.x;
        o_y     = w_head.y;
        o_done  = r_done;
        o_err   = r_err;
    end

endmodule

// File: tb/tb_library_fetch.sv
// Directed bench for library_fetch with a 2-cycle-latency SRAM model.
module tb_library_fetch;

    localparam logic [19:0] PARK = 20'h06C00;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [4:0]  i_slot;
    logic [10:0] i_count;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_rd_en;
    logic [19:0] o_addr;
    logic [9:0]  i_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_x;
    logic [4:0]  o_y;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    library_fetch dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_slot  (i_slot),
        .i_count (i_count),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_rd_en (o_rd_en),
        .o_addr  (o_addr),
        .i_rdata (i_rdata),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_x     (o_x),
        .o_y     (o_y)
    );

    // SRAM model: data = addr[9:0] ^ addr[19:10], valid two cycles after the strobe.
    logic [1:0]  sram_v = 2'b00;
    logic [19:0] sram_a0 = '0;
    logic [19:0] sram_a1 = '0;
    always @(posedge clk) begin
        sram_v  <= {sram_v[0], o_rd_en};
        sram_a0 <= o_addr;
        sram_a1 <= sram_a0;
    end
    assign i_rdata = sram_v[1] ? (sram_a1[9:0] ^ sram_a1[19:10]) : 10'h3FF;

    function automatic logic [9:0] exp_pt(input int slot, input int idx);
        logic [9:0] a;
        logic [9:0] b;
        a = 10'(idx);
        b = 10'(slot * 2);
        return a ^ b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pt(input string tag, input int slot, input int idx);
        logic [9:0] e;
        e = exp_pt(slot, idx);
        chk({tag, "_x"}, 32'(o_x), 32'(e[9:5]));
        chk({tag, "_y"}, 32'(o_y), 32'(e[4:0]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
        chk({tag, "_err"},   32'(o_err),   32'd0);
        chk({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
        chk({tag, "_addr"},  32'(o_addr),  32'(PARK));
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_x"},     32'(o_x),     32'd0);
        chk({tag, "_y"},     32'(o_y),     32'd0);
    endtask

    initial begin
        int nrd;
        int npop;
        int ndone;
        int done_k;
        logic [19:0] last_addr;
        logic        exp_rd;
        int          exp_idx;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_slot  = '0;
        i_count = '0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        i_rst_n = 1'b1;
        @(negedge clk);

        // Slot 3, 5 points, ready always high.
        i_slot = 5'd3; i_count = 11'd5; i_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            exp_rd = (k >= 1 && k <= 5);
            chk("t1_rd", 32'(o_rd_en), 32'(exp_rd));
            chk("t1_addr", 32'(o_addr), exp_rd ? 32'(20'h01800 + 20'(k - 1)) : 32'(PARK));
            chk("t1_valid", 32'(o_valid), 32'(k >= 4 && k <= 8));
            if (k >= 4 && k <= 8) chk_pt("t1_pt", 3, k - 4);
            chk("t1_done", 32'(o_done), 32'(k == 11));
            chk("t1_busy", 32'(o_busy), 32'(k <= 10));
        end

        // Same fetch with ready low for cycles 4..13: reads stall at full credit.
        i_slot = 5'd3; i_count = 11'd5; i_start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_ready = !(k >= 4 && k <= 13);
            exp_rd  = (k >= 1 && k <= 4) || (k == 15);
            exp_idx = (k == 15) ? 4 : k - 1;
            chk("t2_rd", 32'(o_rd_en), 32'(exp_rd));
            chk("t2_addr", 32'(o_addr), exp_rd ? 32'(20'h01800 + 20'(exp_idx)) : 32'(PARK));
            chk("t2_valid", 32'(o_valid), 32'(k >= 4 && k <= 18));
            if (k >= 4 && k <= 18) chk_pt("t2_pt", 3, (k <= 14) ? 0 : k - 14);
            chk("t2_done", 32'(o_done), 32'(k == 21));
            chk("t2_busy", 32'(o_busy), 32'(k <= 20));
        end
        i_ready = 1'b1;

        // Zero count: straight to DONE, no reads, no output.
        i_slot = 5'd3; i_count = 11'd0; i_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            chk("t3_rd", 32'(o_rd_en), 32'd0);
            chk("t3_valid", 32'(o_valid), 32'd0);
            chk("t3_done", 32'(o_done), 32'(k == 2));
            chk("t3_busy", 32'(o_busy), 32'(k == 1));
        end

        // Out-of-range slot: error pulse, stays idle.
        i_slot = 5'd26; i_count = 11'd5; i_start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            chk("t4_err", 32'(o_err), 32'(k == 1));
            chk("t4_busy", 32'(o_busy), 32'd0);
            chk("t4_rd", 32'(o_rd_en), 32'd0);
            chk("t4_addr", 32'(o_addr), 32'(PARK));
        end

        // Slot 25 with count 2047 clamps to 1024 points.
        nrd = 0; npop = 0; ndone = 0; done_k = 0; last_addr = '0;
        i_slot = 5'd25; i_count = 11'd2047; i_start = 1'b1;
        for (int k = 1; k <= 1040; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_rd_en) begin
                chk("t5_addr", 32'(o_addr), 32'(20'h0C800 + 20'(nrd)));
                last_addr = o_addr;
                nrd++;
            end
            if (o_valid) begin
                chk_pt("t5_pt", 25, npop);
                npop++;
            end
            if (o_done) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
        end
        chk("t5_nrd", 32'(nrd), 32'd1024);
        chk("t5_last_addr", 32'(last_addr), 32'h0CBFF);
        chk("t5_npop", 32'(npop), 32'd1024);
        chk("t5_ndone", 32'(ndone), 32'd1);
        chk("t5_done_k", 32'(done_k), 32'd1030);
        chk("t5_busy", 32'(o_busy), 32'd0);

        // Reset in FETCH with two reads in flight; late returns must be dropped.
        i_slot = 5'd3; i_count = 11'd5; i_start = 1'b1; i_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        chk("t6_pre_rd", 32'(o_rd_en), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        @(negedge clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t6_valid", 32'(o_valid), 32'd0);
            chk("t6_busy", 32'(o_busy), 32'd0);
            chk("t6_rd", 32'(o_rd_en), 32'd0);
        end

        // Fresh fetch after reset: slot 7, 3 points.
        i_slot = 5'd7; i_count = 11'd3; i_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            exp_rd = (k >= 1 && k <= 3);
            chk("t7_rd", 32'(o_rd_en), 32'(exp_rd));
            chk("t7_addr", 32'(o_addr), exp_rd ? 32'(20'h03800 + 20'(k - 1)) : 32'(PARK));
            chk("t7_valid", 32'(o_valid), 32'(k >= 4 && k <= 6));
            if (k >= 4 && k <= 6) chk_pt("t7_pt", 7, k - 4);
            chk("t7_done", 32'(o_done), 32'(k == 9));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
